// File: rtl/systolic_input_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_input_feeder: FIFO-buffered row-vector feeder for triangle skew
// arrays, appending ROWS-1 zero vectors per tile to drain the deepest lane.
// Revision: 1.0
// ---------------------------------------------------------------------------
module systolic_input_feeder #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic                       out_enable,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic                       out_first,
  output logic                       tile_done,
  output logic                       busy
);

  localparam int VW = ROWS * DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(ROWS - 1);
  localparam bit            SINGLE_ROW = (ROWS == 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [VW:0]     mem_q [DEPTH];
  logic            en_q, en_d;
  logic [VW-1:0]   data_q, data_d;
  logic            first_q, first_d;
  logic            done_q, done_d;

  logic            push;
  logic            pop;
  logic            not_empty;
  logic [VW:0]     head;
  logic            head_last;
  logic [VW-1:0]   head_data;

  assign in_ready  = (count_q != FULL) & ~rst;
  assign push      = in_valid & in_ready;
  assign not_empty = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[VW];
  assign head_data = head[VW-1:0];

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    en_d    = 1'b0;
    data_d  = data_q;
    first_d = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_d = '0;
        // Waiting out the tile_done cycle leaves one idle output cycle between tiles.
        if (not_empty && !done_q) begin
          pop     = 1'b1;
          en_d    = 1'b1;
          data_d  = head_data;
          first_d = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (not_empty) begin
          pop    = 1'b1;
          en_d   = 1'b1;
          data_d = head_data;
        end
      end
      S_FLUSH: begin
        en_d    = 1'b1;
        data_d  = '0;
        flush_d = flush_q - FW'(1);
        if (flush_q == FW'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop && head_last) begin
      if (SINGLE_ROW) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        flush_d = FLUSH_LOAD;
        state_d = S_FLUSH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      flush_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      en_q    <= en_d;
      data_q  <= data_d;
      first_q <= first_d;
      done_q  <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_data};
    end
  end

  assign out_enable = en_q;
  assign out_data   = data_q;
  assign out_first  = first_q;
  assign tile_done  = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_input_feeder.sv
`default_nettype none
// tb_systolic_input_feeder: randomized stimulus checked against a queue-based
// model of the expected output stream (data vectors plus zero tail per tile).
module tb_systolic_input_feeder;

  localparam int ROWS  = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int VW    = ROWS * DW;
  localparam int HN    = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic          out_enable;
  logic [VW-1:0] out_data;
  logic          out_first;
  logic          tile_done;
  logic          busy;

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int done_total = 0;

  typedef struct {
    logic [VW-1:0] data;
    logic          first;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  bit   tile_open = 1'b0;

  logic          en_h    [HN];
  logic [VW-1:0] data_h  [HN];
  logic          first_h [HN];
  logic          done_h  [HN];
  logic          rdy_h   [HN];
  logic          busy_h  [HN];

  systolic_input_feeder #(
    .ROWS       (ROWS),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_enable (out_enable),
    .out_data   (out_data),
    .out_first  (out_first),
    .tile_done  (tile_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-stream scoreboard plus per-cycle history for timing checks.
  always @(negedge clk) begin
    exp_t e;
    if (cyc < HN) begin
      en_h[cyc]    = out_enable;
      data_h[cyc]  = out_data;
      first_h[cyc] = out_first;
      done_h[cyc]  = tile_done;
      rdy_h[cyc]   = in_ready;
      busy_h[cyc]  = busy;
    end
    if (rst === 1'b0) begin
      if (tile_done === 1'b1) done_total++;
      checks++;
      if (out_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra cyc=%0d got data=%h first=%b done=%b, expected no output",
                   cyc, out_data, out_first, tile_done);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_first !== e.first || tile_done !== e.done) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d got data=%h first=%b done=%b, expected data=%h first=%b done=%b",
                     cyc, out_data, out_first, tile_done, e.data, e.first, e.done);
          end
        end
      end else if (out_first !== 1'b0 || tile_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_flags cyc=%0d got first=%b done=%b, expected 0 0", cyc, out_first, tile_done);
      end
    end
  end

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = DW'($urandom);
    v[0] = 1'b1;
    return v;
  endfunction

  function automatic void model_push(input logic [VW-1:0] d, input logic last);
    exp_t e;
    e.data  = d;
    e.first = !tile_open;
    e.done  = last && (ROWS == 1);
    exp_q.push_back(e);
    tile_open = !last;
    if (last) begin
      for (int k = 1; k < ROWS; k++) begin
        e.data  = '0;
        e.first = 1'b0;
        e.done  = (k == ROWS - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [VW-1:0] d, input logic last, output int acc);
    int waited;
    bit fin;
    waited   = 0;
    fin      = 1'b0;
    acc      = -1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!fin) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = cyc;
        model_push(d, last);
        fin = 1'b1;
      end else if (++waited > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready=%b for 50 cycles, expected 1", in_ready);
        fin = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d outputs pending, expected 0", exp_q.size());
    end
    idle(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_busy got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = rand_vec();
    in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_enable !== 1'b0 || out_data !== '0 || busy !== 1'b0 ||
          tile_done !== 1'b0 || out_first !== 1'b0) begin
        errors++;
        $display("FAIL reset_state got ready=%b en=%b data=%h busy=%b done=%b first=%b, expected all 0",
                 in_ready, out_enable, out_data, busy, tile_done, out_first);
      end
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b, expected 1", in_ready);
    end
    checks++;
    if (out_enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got en=%b busy=%b, expected 0 0", out_enable, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_tile();
    logic [VW-1:0] vecs [4];
    int acc [4];
    int a;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < ROWS; i++) vecs[v][i*DW +: DW] = DW'((i + 1) + 16 * v);
    end
    for (int v = 0; v < 4; v++) send(vecs[v], (v == 3), acc[v]);
    drain();
    a = acc[0];
    checks++;
    if (acc[3] - acc[0] != 3) begin
      errors++;
      $display("FAIL single_contiguous got span=%0d, expected 3", acc[3] - acc[0]);
    end
    checks++;
    if (en_h[a+1] !== 1'b0 || data_h[a+2] !== vecs[0]) begin
      errors++;
      $display("FAIL single_latency got en@+1=%b data@+2=%h, expected 0 %h", en_h[a+1], data_h[a+2], vecs[0]);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (en_h[a+2+k] !== 1'b1 || first_h[a+2+k] !== (k == 0) || done_h[a+2+k] !== (k == 6)) begin
        errors++;
        $display("FAIL single_window k=%0d got en=%b first=%b done=%b, expected 1 %b %b",
                 k, en_h[a+2+k], first_h[a+2+k], done_h[a+2+k], (k == 0), (k == 6));
      end
    end
    checks++;
    if (en_h[a+9] !== 1'b0 || busy_h[a+2] !== 1'b1) begin
      errors++;
      $display("FAIL single_end got en@+9=%b busy@+2=%b, expected 0 1", en_h[a+9], busy_h[a+2]);
    end
  endtask

  task automatic test_full_fifo();
    int acc1 [2];
    int acc2 [6];
    int f;
    send(rand_vec(), 1'b0, acc1[0]);
    send(rand_vec(), 1'b1, acc1[1]);
    for (int j = 0; j < 6; j++) send(rand_vec(), (j == 5), acc2[j]);
    drain();
    checks++;
    if (acc2[3] - acc2[0] != 3 || acc2[4] - acc2[3] <= 1) begin
      errors++;
      $display("FAIL full_accept got spans %0d %0d, expected 3 and >1", acc2[3] - acc2[0], acc2[4] - acc2[3]);
    end
    checks++;
    if (rdy_h[acc2[3]+1] !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_low got %b, expected 0", rdy_h[acc2[3]+1]);
    end
    f = -1;
    for (int c = acc2[0] + 1; c < acc2[0] + 30 && f < 0; c++) if (first_h[c] === 1'b1) f = c;
    checks++;
    if (f < 0 || rdy_h[f] !== 1'b1 || rdy_h[f-1] !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_return got first_cyc=%0d, expected ready 0 then 1 around it", f);
    end
  endtask

  task automatic test_bubble();
    logic [VW-1:0] v0;
    int a0, a1, a2, cnt, n;
    bit seen;
    v0 = rand_vec();
    send(v0, 1'b0, a0);
    idle(2);
    send(rand_vec(), 1'b0, a1);
    send(rand_vec(), 1'b1, a2);
    drain();
    n = a0;
    checks++;
    if (en_h[n+3] !== 1'b0 || en_h[n+4] !== 1'b0 || data_h[n+3] !== v0 || data_h[n+4] !== v0) begin
      errors++;
      $display("FAIL bubble_hold got en=%b%b data=%h %h, expected 00 %h", en_h[n+3], en_h[n+4],
               data_h[n+3], data_h[n+4], v0);
    end
    cnt  = 0;
    seen = 1'b0;
    for (int c = n + 2; c < n + 22 && !seen; c++) begin
      if (en_h[c] === 1'b1) cnt++;
      if (done_h[c] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (cnt != 6 || !seen) begin
      errors++;
      $display("FAIL bubble_enable_count got %0d done_seen=%b, expected 6 1", cnt, seen);
    end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int d1, f2, nd;
    for (int j = 0; j < 4; j++) send(rand_vec(), (j % 2 == 1), acc[j]);
    drain();
    d1 = -1;
    f2 = -1;
    nd = 0;
    for (int c = acc[0]; c < acc[0] + 30; c++) begin
      if (done_h[c] === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = c;
      end
      if (d1 >= 0 && f2 < 0 && first_h[c] === 1'b1) f2 = c;
    end
    checks++;
    if (nd != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d, expected 2", nd);
    end
    checks++;
    if (d1 < 0 || f2 - d1 != 2 || en_h[d1+1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got done=%0d first=%0d, expected first two cycles after done", d1, f2);
    end
  endtask

  task automatic test_reset_mid_flush();
    int a, zeros, w, d0, en_seen;
    send(rand_vec(), 1'b0, a);
    send(rand_vec(), 1'b1, a);
    send(rand_vec(), 1'b0, a);
    send(rand_vec(), 1'b0, a);
    zeros = 0;
    w     = 0;
    while (zeros < 2 && w < 40) begin
      @(negedge clk);
      if (out_enable === 1'b1 && out_data === '0) zeros++;
      w++;
    end
    checks++;
    if (zeros < 2) begin
      errors++;
      $display("FAIL midflush_timeout got %0d zero vectors, expected 2", zeros);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tile_open = 1'b0;
    d0 = done_total;
    @(negedge clk);
    checks++;
    if (out_enable !== 1'b0 || busy !== 1'b0 || tile_done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflush_after_reset got en=%b busy=%b done=%b ready=%b, expected 0 0 0 1",
               out_enable, busy, tile_done, in_ready);
    end
    en_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_enable !== 1'b0) en_seen++;
    end
    checks++;
    if (en_seen != 0 || done_total != d0) begin
      errors++;
      $display("FAIL midflush_discard got enables=%0d dones=%0d, expected 0 0", en_seen, done_total - d0);
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) send(rand_vec(), (j == 2), a);
    drain();
    checks++;
    if (done_total != d0 + 1) begin
      errors++;
      $display("FAIL midflush_next_tile got %0d dones, expected 1", done_total - d0);
    end
  endtask

  task automatic test_random_tiles();
    int d0, len, a;
    d0 = done_total;
    for (int t = 0; t < 6; t++) begin
      len = int'($urandom_range(1, 5));
      for (int j = 0; j < len; j++) begin
        send(rand_vec(), (j == len - 1), a);
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    drain();
    checks++;
    if (done_total - d0 != 6) begin
      errors++;
      $display("FAIL random_done_count got %0d, expected 6", done_total - d0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    test_reset();
    test_single_tile();
    test_full_fifo();
    test_bubble();
    test_back_to_back();
    test_reset_mid_flush();
    test_random_tiles();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
